// File: rtl/bpsk_pkg.sv
// bpsk_pkg: shared width helpers, FSM states and default constants for the BPSK frame synchroniser
package bpsk_pkg;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int acc_width(input int data_w, input int sps, input int pre_syms);
    return data_w + clog2(pre_syms * sps) + 2;
  endfunction
  function automatic int cnt_width(input int n);
    return n > 1 ? clog2(n) : 1;
  endfunction
  typedef enum logic {SEARCH, LOCKED} state_t;
  localparam logic [19:0] DEF_PREAMBLE = 20'h9F183;
  localparam logic [9:0] DEF_EOF_WORD = 10'h143;
endpackage

// File: rtl/bpsk_preamble_corr.sv
// bpsk_preamble_corr: sample history and recursive sign-weighted preamble correlator
module bpsk_preamble_corr
  import bpsk_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SPS = 25,
  parameter int PRE_SYMS = 20,
  parameter logic [PRE_SYMS-1:0] PREAMBLE = DEF_PREAMBLE,
  parameter int ACC_W = acc_width(DATA_W, SPS, PRE_SYMS)
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     shift,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [ACC_W-1:0]  c_nxt,
  output logic signed [ACC_W-1:0]  corr
);
  localparam int N = PRE_SYMS * SPS;
  logic signed [DATA_W-1:0] h [N];
  // only samples crossing a tap boundary change the sum, by twice their value where signs flip
  always_comb begin
    logic signed [ACC_W-1:0] e;
    e = x;
    c_nxt = PREAMBLE[0] ? corr + e : corr - e;
    for (int k = 1; k < PRE_SYMS; k++) begin
      e = h[k*SPS-1];
      if (PREAMBLE[k] != PREAMBLE[k-1]) c_nxt = PREAMBLE[k] ? c_nxt + (e <<< 1) : c_nxt - (e <<< 1);
    end
    e = h[N-1];
    c_nxt = PREAMBLE[PRE_SYMS-1] ? c_nxt - e : c_nxt + e;
  end
  always_ff @(posedge clk)
    if (clear) begin
      corr <= '0;
      for (int i = 0; i < N; i++) h[i] <= '0;
    end else if (shift) begin
      corr <= c_nxt;
      h[0] <= x;
      for (int i = 1; i < N; i++) h[i] <= h[i-1];
    end
endmodule

// File: rtl/bpsk_frame_sync.sv
// bpsk_frame_sync: preamble search, polarity-resolved symbol slicing and framed word output
module bpsk_frame_sync
  import bpsk_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SPS = 25,
  parameter int PRE_SYMS = 20,
  parameter logic [PRE_SYMS-1:0] PREAMBLE = DEF_PREAMBLE,
  parameter int FRAME_SYMS = 10,
  parameter int SAMPLE_PHASE = 12,
  parameter logic [FRAME_SYMS-1:0] EOF_WORD = DEF_EOF_WORD,
  parameter int MAX_WORDS = 64,
  localparam int ACC_W = acc_width(DATA_W, SPS, PRE_SYMS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [ACC_W-1:0]         thresh,
  output logic signed [ACC_W-1:0]  corr,
  output logic                     locked,
  output logic                     lock_polarity,
  output logic                     word_valid,
  output logic [FRAME_SYMS-1:0]    word,
  output logic                     word_eof
);
  localparam int PW = cnt_width(SPS);
  localparam int SW = cnt_width(FRAME_SYMS);
  localparam int WW = cnt_width(MAX_WORDS + 1);
  state_t state;
  logic [PW-1:0] phase_cnt;
  logic [SW-1:0] sym_cnt;
  logic [WW-1:0] word_cnt;
  logic [FRAME_SYMS-1:0] bits, nbits;
  logic signed [ACC_W-1:0] c_nxt;
  logic signed [ACC_W:0] ce, te;
  logic hit, exit_lock, bit_in;
  always_comb begin
    ce = c_nxt;
    te = {1'b0, thresh};
    hit = ce > te || ce < -te;
    exit_lock = state == LOCKED && word_valid && (word_eof || word_cnt == WW'(MAX_WORDS));
    bit_in = ~in_data[DATA_W-1] ^ lock_polarity;
    nbits = bits;
    nbits[sym_cnt] = bit_in;
  end
  bpsk_preamble_corr #(
    .DATA_W(DATA_W), .SPS(SPS), .PRE_SYMS(PRE_SYMS), .PREAMBLE(PREAMBLE), .ACC_W(ACC_W)
  ) u_corr (
    .clk(clk),
    .clear(reset || exit_lock),
    .shift(in_valid && state == SEARCH),
    .x(in_data),
    .c_nxt(c_nxt),
    .corr(corr)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= SEARCH;
      locked <= 1'b0;
      lock_polarity <= 1'b0;
      word_valid <= 1'b0;
      word_eof <= 1'b0;
      word <= '0;
      bits <= '0;
      phase_cnt <= '0;
      sym_cnt <= '0;
      word_cnt <= '0;
    end else begin
      word_valid <= 1'b0;
      word_eof <= 1'b0;
      if (exit_lock) begin
        state <= SEARCH;
        locked <= 1'b0;
      end else if (state == SEARCH) begin
        if (in_valid && hit) begin
          state <= LOCKED;
          locked <= 1'b1;
          lock_polarity <= c_nxt[ACC_W-1];
          phase_cnt <= '0;
          sym_cnt <= '0;
          word_cnt <= '0;
        end
      end else if (in_valid) begin
        phase_cnt <= phase_cnt == PW'(SPS-1) ? '0 : phase_cnt + PW'(1);
        if (phase_cnt == PW'(SAMPLE_PHASE)) begin
          bits <= nbits;
          sym_cnt <= sym_cnt == SW'(FRAME_SYMS-1) ? '0 : sym_cnt + SW'(1);
          if (sym_cnt == SW'(FRAME_SYMS-1)) begin
            word_valid <= 1'b1;
            word <= nbits;
            word_eof <= nbits == EOF_WORD;
            word_cnt <= word_cnt + WW'(1);
          end
        end
      end
    end
endmodule

// File: tb/tb_bpsk_frame_sync.sv
// tb_bpsk_frame_sync: random and directed stimulus against a direct-sum, sample-counting reference model
module tb_bpsk_frame_sync;
  localparam int SPS = 4, NS = 4, FS = 4, PH = 1, MAXW = 3, N = 16, TH = 120;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic signed [7:0] in_data = '0;
  logic [13:0] thresh = 14'd120;
  logic signed [13:0] corr;
  logic locked, lock_polarity, word_valid, word_eof;
  logic [3:0] word;
  logic [3:0] pre = 4'b1011;
  logic [3:0] eofw = 4'hA;
  int vectors = 0, miscompares = 0;
  int hist[$];
  int seen[$];
  int e_corr = 0, m_samp = 0, m_words = 0;
  bit e_lk = 0, e_pol = 0, e_wv = 0, e_eof = 0, prev_eof = 0;
  bit [3:0] e_word = 0, m_bits = 0;
  always #5 clk = ~clk;
  bpsk_frame_sync #(
    .DATA_W(8), .SPS(4), .PRE_SYMS(4), .PREAMBLE(4'b1011), .FRAME_SYMS(4),
    .SAMPLE_PHASE(1), .EOF_WORD(4'hA), .MAX_WORDS(3)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .thresh(thresh),
    .corr(corr), .locked(locked), .lock_polarity(lock_polarity), .word_valid(word_valid),
    .word(word), .word_eof(word_eof)
  );
  task automatic chk(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int dsum();
    int s = 0;
    foreach (hist[i]) s += pre[i/SPS] ? hist[i] : -hist[i];
    return s;
  endfunction
  task automatic mstep(input bit v, input int x);
    bit exit_now;
    int sn;
    exit_now = e_wv && (e_eof || m_words == MAXW);
    e_wv = 0;
    e_eof = 0;
    if (reset) begin
      hist.delete();
      e_corr = 0; e_lk = 0; e_pol = 0; e_word = 0; m_words = 0;
    end else if (exit_now) begin
      hist.delete();
      e_corr = 0; e_lk = 0;
    end else if (!e_lk && v) begin
      hist.push_front(x);
      if (hist.size() > N) void'(hist.pop_back());
      e_corr = dsum();
      if (e_corr > TH || e_corr < -TH) begin
        e_lk = 1; e_pol = e_corr < 0; m_samp = 0; m_words = 0;
      end
    end else if (e_lk && v) begin
      if (m_samp % SPS == PH) begin
        sn = (m_samp / SPS) % FS;
        m_bits[sn] = (x >= 0) ^ e_pol;
        if (sn == FS - 1) begin
          e_wv = 1; e_word = m_bits; e_eof = m_bits == eofw; m_words++;
        end
      end
      m_samp++;
    end
  endtask
  task automatic cycle(input bit v, input int x);
    in_valid = v;
    in_data = 8'(x);
    @(posedge clk);
    mstep(v, x);
    #1;
    chk("corr", corr, e_corr);
    chk("locked", locked, e_lk);
    chk("polarity", lock_polarity, e_pol);
    chk("word_valid", word_valid, e_wv);
    chk("word", word, e_word);
    chk("word_eof", word_eof, e_eof);
    if (prev_eof) begin
      chk("post_eof_locked", locked, 0);
      chk("post_eof_corr", corr, 0);
    end
    prev_eof = word_valid && word_eof;
    if (word_valid) seen.push_back(word);
  endtask
  task automatic sym(input int s, input int amp, input int gap);
    for (int i = 0; i < SPS; i++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) cycle(0, int'($urandom_range(0, 255)) - 128);
      cycle(1, s * amp);
    end
  endtask
  task automatic pre_send(input int amp);
    for (int k = NS - 1; k >= 0; k--) sym(pre[k] ? 1 : -1, amp, 0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cycle(0, 0);
    cycle(1, 9);
    reset = 1'b0;
    seen.delete();
  endtask
  initial begin
    bit [3:0] w;
    int s;
    do_reset();
    pre_send(10);
    chk("t1_corr", corr, 160);
    chk("t1_locked", locked, 1);
    chk("t1_pol", lock_polarity, 0);
    do_reset();
    pre_send(-10);
    chk("t2_corr", corr, -160);
    chk("t2_pol", lock_polarity, 1);
    sym(-1, 10, 0); sym(1, 10, 0); sym(-1, 10, 0); sym(-1, 10, 0);
    chk("t2_nwords", seen.size(), 1);
    chk("t2_word", seen.size() > 0 ? seen[0] : -1, 13);
    do_reset();
    pre_send(10);
    sym(1, 10, 0); sym(-1, 10, 0); sym(1, 10, 0); sym(-1, 10, 0);
    sym(-1, 10, 0); sym(1, 10, 0); sym(-1, 10, 0); sym(1, 10, 0);
    chk("t3_nwords", seen.size(), 2);
    chk("t3_word0", seen.size() > 0 ? seen[0] : -1, 5);
    chk("t3_word1", seen.size() > 1 ? seen[1] : -1, 10);
    chk("t3_locked", locked, 0);
    do_reset();
    pre_send(10);
    for (int i = 0; i < 4 * FS; i++) sym(1, 10, 0);
    chk("t4_nwords", seen.size(), 3);
    chk("t4_locked", locked, 0);
    do_reset();
    pre_send(7);
    chk("t5_corr", corr, 112);
    chk("t5_locked", locked, 0);
    for (int i = 0; i < 2000; i++)
      if ($urandom_range(0, 9) == 0) cycle(0, 77);
      else cycle(1, $urandom_range(0, 1) ? 10 : -10);
    do_reset();
    pre_send(10);
    for (int j = 0; j < 2; j++) begin
      w = '0;
      for (int k = 0; k < FS; k++) begin
        s = $urandom_range(0, 1) ? 1 : -1;
        w[k] = s > 0;
        sym(s, 10, 5);
      end
      chk("t6_word", seen.size() > j ? seen[j] : -1, w);
    end
    sym(1, 10, 5);
    sym(-1, 10, 5);
    reset = 1'b1;
    cycle(1, 10);
    reset = 1'b0;
    chk("t6_rst_corr", corr, 0);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_pol", lock_polarity, 0);
    chk("t6_rst_wv", word_valid, 0);
    chk("t6_rst_word", word, 0);
    chk("t6_rst_eof", word_eof, 0);
    cycle(0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
